rng_share_scheduler: RTL and testbench

//  Owns one Fibonacci LFSR and shares its stream among N Monte Carlo path engines.

---
 rtl/rng_share_scheduler.sv | 146 ++++++++++++++
 tb/tb_rng_share_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_share_scheduler.sv
// rng_share_scheduler
//   Owns one Fibonacci LFSR and shares its output among N requesters
//   (Monte Carlo path engines). After reset or a seed load the generator
//   runs WARMUP discarded shifts, then serves requests round-robin, handing
//   each LFSR value to exactly one engine. Cycles with no grant do not
//   advance the LFSR, so no value is ever skipped or repeated.
//
// Handshake: req[i] is a level held until the engine sees gnt[i]; the engine
//   drops req[i] in the same cycle gnt[i] is high, otherwise it is eligible
//   again. gnt is a registered one-hot pulse and rnd_data is valid exactly
//   while rnd_valid (= |gnt) is high.
//
// Optional feature macro: RNG_ZERO_GUARD_EN
//   Defined   : a zero seed loads DEFAULT_SEED instead, and an all-zero
//               LFSR state reloads DEFAULT_SEED and restarts warm-up.
//   Undefined : seeds load verbatim; a zero seed gives a constant-zero stream.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   seed_load  1-cycle pulse: load seed and restart warm-up (beats a grant)
//   seed       seed value, sampled with seed_load
//   req        per-engine request levels
//   gnt        one-hot grant pulse (registered)
//   rnd_valid  rnd_data valid this cycle
//   rnd_data   random word for the granted engine
//   ready      high in RUN (the FSM state is visible through this output)
module rng_share_scheduler #(
  parameter int           N            = 4,
  parameter int           W            = 16,
  parameter logic [W-1:0] TAPS         = 16'hB400,
  parameter int           WARMUP       = 4,
  parameter logic [W-1:0] DEFAULT_SEED = 16'h0001
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_load,
  input  logic [W-1:0] seed,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         rnd_valid,
  output logic [W-1:0] rnd_data,
  output logic         ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  // Count value reached on the final warm-up shift.
  localparam logic [7:0] WARM_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

  typedef enum logic [0:0] {
    WARM = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  fsm_t          fsm;
  logic [W-1:0]  lfsr;
  logic [W-1:0]  lfsr_next;
  logic [7:0]    warm_cnt;
  logic [PW-1:0] ptr;
  logic          found;
  logic [PW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic [W-1:0]  seed_eff;

  assign lfsr_next = {lfsr[W-2:0], ^(lfsr & TAPS)};

`ifdef RNG_ZERO_GUARD_EN
  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;
`else
  assign seed_eff = seed;
`endif

  // Round-robin search: first set request after the last winner, wrapping.
  always_comb begin
    found   = 1'b0;
    win_idx = ptr;
    win_oh  = '0;
    for (int i = 1; i <= N; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = PW'(idx);
      end
    end
    if (found) win_oh[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm      <= WARM;
      lfsr     <= DEFAULT_SEED;
      warm_cnt <= '0;
      ptr      <= PW'(N - 1);
      gnt      <= '0;
      rnd_data <= '0;
    end else begin
      gnt <= '0;
      if (seed_load) begin
        // Seed load wins over any grant this cycle; held requests stay pending.
        lfsr     <= seed_eff;
        fsm      <= WARM;
        warm_cnt <= '0;
      end
`ifdef RNG_ZERO_GUARD_EN
      else if (lfsr == '0) begin
        lfsr     <= DEFAULT_SEED;
        fsm      <= WARM;
        warm_cnt <= '0;
      end
`endif
      else begin
        case (fsm)
          WARM: begin
            if (WARMUP == 0) begin
              fsm <= RUN;
            end else begin
              lfsr <= lfsr_next;
              if (warm_cnt == WARM_LAST) begin
                fsm      <= RUN;
                warm_cnt <= '0;
              end else begin
                warm_cnt <= warm_cnt + 8'd1;
              end
            end
          end
          RUN: begin
            // The LFSR advances only when a value is actually handed out.
            if (found) begin
              gnt      <= win_oh;
              rnd_data <= lfsr;
              lfsr     <= lfsr_next;
              ptr      <= win_idx;
            end
          end
          default: fsm <= WARM;
        endcase
      end
    end
  end

  assign rnd_valid = |gnt;
  assign ready     = (fsm == RUN);

endmodule

// File: tb/tb_rng_share_scheduler.sv
// Bench for rng_share_scheduler (N=4, W=16, WARMUP=4, seed 16'h0001).
// Each engine is modelled by a pending-grant count; its req is high while
// the count is nonzero and the count drops when the engine sees its gnt.
// Expected grants are pushed to exp_q before the DUT can produce them and
// popped by the monitor on the falling edge.
module tb_rng_share_scheduler;

  localparam int           N      = 4;
  localparam int           W      = 16;
  localparam logic [W-1:0] TAPS   = 16'hB400;
  localparam int           WARMUP = 4;
  localparam logic [W-1:0] DSEED  = 16'h0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n     = 1'b0;
  logic         seed_load = 1'b0;
  logic [W-1:0] seed      = '0;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         rnd_valid;
  logic [W-1:0] rnd_data;
  logic         ready;

  rng_share_scheduler #(
    .N(N), .W(W), .TAPS(TAPS), .WARMUP(WARMUP), .DEFAULT_SEED(DSEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .req       (req),
    .gnt       (gnt),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .ready     (ready)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int pend[N];
  logic [N+W-1:0] exp_q[$];
  logic [W-1:0]   m_state;
  int             m_ptr;

  initial for (int i = 0; i < N; i++) pend[i] = 0;

  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) req[i] = (pend[i] != 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & TAPS)};
  endfunction

  function automatic logic [W-1:0] warm_from(input logic [W-1:0] s);
    logic [W-1:0] t;
    t = s;
    for (int i = 0; i < WARMUP; i++) t = lfsr_step(t);
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  // Main-thread actions happen shortly after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called on the tick right after the edge that applied reset/seed_load.
  task automatic count_not_ready(output int n);
    n = 0;
    while (!ready && n < 50) begin
      n++;
      tick();
    end
  endtask

  // Predict the grants for the current pending counts, assuming every
  // engine with work holds req continuously until served.
  task automatic push_burst();
    int rem[N];
    for (int i = 0; i < N; i++) rem[i] = pend[i];
    for (int g = 0; g < 64; g++) begin
      bit hit;
      hit = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        logic [N-1:0] oh;
        idx = (m_ptr + k) % N;
        if (!hit && rem[idx] > 0) begin
          hit = 1'b1;
          oh = '0;
          oh[idx] = 1'b1;
          rem[idx]--;
          exp_q.push_back({oh, m_state});
          m_state = lfsr_step(m_state);
          m_ptr = idx;
        end
      end
      if (!hit) break;
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      t++;
      tick();
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_rnd_valid"}, 32'(rnd_valid), 0);
    check({tag, "_rnd_data"}, 32'(rnd_data), 0);
    check({tag, "_ready"}, 32'(ready), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rnd_valid || (gnt != '0)) begin
      check("valid_is_or_gnt", 32'(rnd_valid), 32'(|gnt));
      if (exp_q.size() == 0) begin
        check("unexpected_gnt", 32'(gnt), 0);
      end else begin
        logic [N+W-1:0] e;
        e = exp_q.pop_front();
        check("gnt", 32'(gnt), 32'(e[N+W-1:W]));
        check("rnd_data", 32'(rnd_data), 32'(e[W-1:0]));
      end
      for (int i = 0; i < N; i++)
        if (gnt[i] && pend[i] > 0) pend[i]--;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;

    // Reset and first stream from the default seed, engine 0 only.
    rst_n = 1'b0;
    idle(2);
    check_reset_outputs("reset");
    pend[0] = 3;
    rst_n = 1'b1;
    count_not_ready(n);
    check("warm_cycles_reset", n, 4);
    exp_q.push_back({4'b0001, 16'h0010});
    exp_q.push_back({4'b0001, 16'h0020});
    exp_q.push_back({4'b0001, 16'h0040});
    drain("t1");
    m_state = 16'h0080;
    m_ptr   = 0;

    // Idle cycles with no request: LFSR must hold.
    idle(5);
    check("ready_idle", 32'(ready), 1);
    pend[3] = 1;
    push_burst();
    drain("idle_hold");

    // All four requesting from pointer 3: 0,1,2,3,0.
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    push_burst();
    drain("rotate");

    // Pointer to 1, then req=1010 -> 1000 then 0010.
    pend[1] = 1;
    push_burst();
    drain("ptr1");
    pend[1] = 1; pend[3] = 1;
    push_burst();
    drain("req1010");
    idle(5);
    pend[$urandom_range(0, N-1)] = 1;
    push_burst();
    drain("idle_hold2");

    // seed_load while all four request: seed wins, warm-up restarts.
    for (int i = 0; i < N; i++) pend[i] = 2;
    seed = 16'h0001;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("seed_no_gnt", 32'(gnt), 0);
    count_not_ready(n);
    check("warm_cycles_seed", n, 4);
    m_state = warm_from(16'h0001);
    push_burst();
    drain("seed_burst");

    // Reset in the middle of a burst.
    for (int i = 0; i < N; i++) pend[i] = 2;
    push_burst();
    n = 0;
    while (exp_q.size() > 5 && n < 50) begin
      n++;
      tick();
    end
    check("burst_progress", 32'(exp_q.size() <= 5), 1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("mid_reset");
    exp_q.delete();
    for (int i = 0; i < N; i++) pend[i] = 0;
    pend[0] = 3;
    rst_n = 1'b1;
    count_not_ready(n);
    check("warm_cycles_rst2", n, 4);
    m_state = warm_from(DSEED);
    m_ptr   = N - 1;
    push_burst();
    drain("restart");

    // Zero seed.
    pend[0] = 3;
    seed = '0;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    count_not_ready(n);
    check("warm_cycles_zero", n, 4);
`ifdef RNG_ZERO_GUARD_EN
    m_state = warm_from(DSEED);
`else
    m_state = '0;
`endif
    push_burst();
    drain("zero_seed");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
